// File: rtl/dmem_dma_if.sv
// dmem_dma_if: command handshake and data-memory port bundle for the block-move engine
interface dmem_dma_if #(parameter int AW = 8, parameter int DW = 8);
    logic          Start;
    logic          Op;
    logic [AW-1:0] SrcAddr;
    logic [AW-1:0] DstAddr;
    logic [AW-1:0] Len;
    logic [DW-1:0] FillVal;
    logic          Abort;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] MemRdAddr;
    logic [DW-1:0] MemRdData;
    logic [AW-1:0] MemWrAddr;
    logic          MemWrEn;
    logic [DW-1:0] MemWrData;

    modport master (
        input  Start, Op, SrcAddr, DstAddr, Len, FillVal, Abort, MemRdData,
        output Busy, Done, MemRdAddr, MemWrAddr, MemWrEn, MemWrData
    );

    modport slave (
        output Start, Op, SrcAddr, DstAddr, Len, FillVal, Abort, MemRdData,
        input  Busy, Done, MemRdAddr, MemWrAddr, MemWrEn, MemWrData
    );
endinterface

// File: rtl/dmem_dma.sv
// dmem_dma: copy/fill engine driving a combinational-read, clocked-write byte memory
module dmem_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    dmem_dma_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic          back_q, back_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] i_q, i_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] diff;
    logic          last;

    // next-state: accept commands when idle, alternate read/write per byte, abort wins in RD/WR
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        back_d  = back_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        fill_d  = fill_q;
        data_d  = data_q;
        diff    = bus.DstAddr - bus.SrcAddr;
        last    = back_q ? (i_q == '0) : (i_q == len_q - AW'(1));
        if ((state_q == RD || state_q == WR) && bus.Abort) begin
            state_d = IDLE;
        end else if (state_q == IDLE || state_q == DONE) begin
            state_d = IDLE;
            if (bus.Start) begin
                op_d    = bus.Op;
                src_d   = bus.SrcAddr;
                dst_d   = bus.DstAddr;
                len_d   = bus.Len;
                fill_d  = bus.FillVal;
                back_d  = !bus.Op && diff != '0 && diff < bus.Len;
                i_d     = back_d ? bus.Len - AW'(1) : '0;
                state_d = bus.Len == '0 ? DONE : (bus.Op ? WR : RD);
            end
        end else if (state_q == RD) begin
            data_d  = bus.MemRdData;
            state_d = WR;
        end else if (last) begin
            state_d = DONE;
        end else begin
            i_d     = back_q ? i_q - AW'(1) : i_q + AW'(1);
            state_d = op_q ? WR : RD;
        end
    end

    // state and operand registers; reset abandons any command in flight
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            back_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            back_q  <= back_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    assign bus.Busy      = state_q == RD || state_q == WR;
    assign bus.Done      = state_q == DONE;
    assign bus.MemRdAddr = state_q == RD ? src_q + i_q : '0;
    assign bus.MemWrEn   = state_q == WR;
    assign bus.MemWrAddr = state_q == WR ? dst_q + i_q : '0;
    assign bus.MemWrData = state_q == WR ? (op_q ? fill_q : data_q) : '0;
endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: scoreboard bench for dmem_dma against a byte-level copy/fill model
module tb_dmem_dma;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [15:0] wq [$];
    int dq [$];
    int cyc = 0;
    int nwr = 0;
    int compared = 0;
    int mismatched = 0;

    dmem_dma_if #(.AW(8), .DW(8)) bus ();

    dmem_dma #(.AW(8), .DW(8)) dut (.Clk(clk), .Reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.MemRdData = mem[bus.MemRdAddr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.MemWrEn) mem[bus.MemWrAddr] <= bus.MemWrData;
    end

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.MemWrEn) begin
                nwr++;
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    logic [15:0] e;
                    e = wq.pop_front();
                    chk("wr_addr", int'(bus.MemWrAddr), int'(e[15:8]));
                    chk("wr_data", int'(bus.MemWrData), int'(e[7:0]));
                end
            end
            if (bus.Done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic setmem(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic mem_check(input string nm);
        int bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic issue(input logic op, input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] len, input logic [7:0] fill, input int nmax, input bit exp_done);
        int a;
        bit back;
        logic [7:0] idx, wa, wd, diff;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op = op;
        bus.SrcAddr = src;
        bus.DstAddr = dst;
        bus.Len = len;
        bus.FillVal = fill;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        a = cyc;
        diff = dst - src;
        back = !op && dst != src && diff < len;
        for (int k = 0; k < int'(len) && k < nmax; k++) begin
            idx = back ? 8'(int'(len) - 1 - k) : 8'(k);
            wa = dst + idx;
            wd = op ? fill : ref_mem[8'(src + idx)];
            ref_mem[wa] = wd;
            wq.push_back({wa, wd});
        end
        if (exp_done) dq.push_back(a + (op ? int'(len) : 2 * int'(len)));
    endtask

    task automatic run(input logic op, input logic [7:0] src, input logic [7:0] dst,
                       input logic [7:0] len, input logic [7:0] fill);
        issue(op, src, dst, len, fill, 1000, 1'b1);
        repeat ((op ? int'(len) : 2 * int'(len)) + 2) @(negedge clk);
        chk("busy_after_cmd", int'(bus.Busy), 0);
        mem_check("mem_after_cmd");
    endtask

    initial begin
        int n0;
        bus.Start = 0; bus.Op = 0; bus.SrcAddr = 0; bus.DstAddr = 0;
        bus.Len = 0; bus.FillVal = 0; bus.Abort = 0;
        for (int k = 0; k < 256; k++) setmem(8'(k), 8'($urandom));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_done", int'(bus.Done), 0);
        chk("rst_wren", int'(bus.MemWrEn), 0);
        chk("rst_rdaddr", int'(bus.MemRdAddr), 0);
        chk("rst_wraddr", int'(bus.MemWrAddr), 0);
        chk("rst_wrdata", int'(bus.MemWrData), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
        setmem(8'h00, 8'd1); setmem(8'h01, 8'd2); setmem(8'h02, 8'd3);
        run(1'b0, 8'h00, 8'h40, 8'd3, 8'h00);
        setmem(8'h20, 8'h0A); setmem(8'h21, 8'h0B); setmem(8'h22, 8'h0C); setmem(8'h23, 8'h0D);
        run(1'b0, 8'h20, 8'h22, 8'd4, 8'h00);
        chk("bwd_22", int'(mem[8'h22]), 'h0A);
        chk("bwd_23", int'(mem[8'h23]), 'h0B);
        chk("bwd_24", int'(mem[8'h24]), 'h0C);
        chk("bwd_25", int'(mem[8'h25]), 'h0D);
        run(1'b0, 8'h22, 8'h20, 8'd4, 8'h00);
        chk("fwd_20", int'(mem[8'h20]), 'h0A);
        chk("fwd_23", int'(mem[8'h23]), 'h0D);
        run(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5C);
        chk("wrap_00", int'(mem[8'h00]), 'h5C);
        run(1'b1, 8'h00, 8'h30, 8'd0, 8'h77);
        run(1'b0, 8'h30, 8'h31, 8'd0, 8'h00);

        issue(1'b0, 8'h50, 8'hA0, 8'd6, 8'h00, 1000, 1'b1);
        repeat (3) @(negedge clk);
        bus.Start = 1'b1; bus.Op = 1'b1; bus.DstAddr = 8'hC0; bus.Len = 8'd9; bus.FillVal = 8'hEE;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_after_ignored_start", int'(bus.Busy), 0);
        mem_check("mem_after_ignored_start");

        n0 = nwr;
        issue(1'b0, 8'h60, 8'h90, 8'd6, 8'h00, 2, 1'b0);
        for (int c = 0; c < 30; c++) begin
            if (nwr >= n0 + 2) break;
            @(negedge clk);
            #1;
        end
        chk("abort_two_writes_seen", nwr - n0, 2);
        @(posedge clk);
        #1 bus.Abort = 1'b1;
        @(posedge clk);
        #1 bus.Abort = 1'b0;
        chk("abort_busy", int'(bus.Busy), 0);
        repeat (4) @(negedge clk);
        chk("abort_write_count", nwr - n0, 2);
        mem_check("mem_after_abort");

        issue(1'b1, 8'h00, 8'h80, 8'd10, 8'h3C, 3, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.Busy), 0);
        chk("mid_rst_wren", int'(bus.MemWrEn), 0);
        chk("mid_rst_done", int'(bus.Done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mem_check("mem_after_reset");
        run(1'b1, 8'h00, 8'h84, 8'd3, 8'h99);

        for (int t = 0; t < 30; t++) begin
            logic [7:0] len;
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            run(1'($urandom), 8'($urandom), 8'($urandom), len, 8'($urandom));
        end

        chk("writes_pending", wq.size(), 0);
        chk("dones_pending", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Memory-side initiator for the 3BC data memory: autonomously issues read/write sequences into a 256-deep byte memory with combinational read and clocked write.
- Executes block COPY (src→dst, memmove-safe) and block FILL (constant→dst) on command from the core or test harness.
- Replaces file-based preload and byte-by-byte software loops.
- Sits between the control path (Start/Busy/Done handshake) and the data memory port.

Parameters:
- AW, 8, address width; memory depth is 2^AW; also the Len width.
- DW, 8, data width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  command strobe; sampled only in IDLE or DONE.
- Op  in  1  0 = COPY, 1 = FILL.
- SrcAddr  in  AW  COPY source base; ignored for FILL.
- DstAddr  in  AW  destination base.
- Len  in  AW  byte count; 0 = no-op.
- FillVal  in  DW  FILL constant.
- Abort  in  1  cancel the active command.
- Busy  out  1  high while a command is executing.
- Done  out  1  one-cycle pulse on normal completion.
- MemRdAddr  out  AW  memory read address.
- MemRdData  in  DW  combinational read data for MemRdAddr.
- MemWrAddr  out  AW  memory write address.
- MemWrEn  out  1  write strobe; memory writes on the same posedge.
- MemWrData  out  DW  write data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - Busy=0, Done=0, MemWrEn=0.
  - MemRdAddr=0, MemWrAddr=0, MemWrData=0.
  - Internal counter and data register cleared.
  - Reset asserted mid-command abandons it; no further writes occur.
- States: IDLE, RD, WR, DONE.
- Command acceptance:
  - In IDLE or DONE, a posedge with Start=1 latches Op, SrcAddr, DstAddr, Len and FillVal.
  - Len=0 → DONE next cycle with zero writes.
  - Otherwise COPY → RD; FILL → WR.
  - Start while Busy=1 is ignored, and latched operands do not change.
- Direction (COPY only), computed at acceptance:
  - backward=1 iff Dst≠Src and ((Dst−Src) mod 2^AW) < Len.
  - Else forward.
  - Index i runs 0..Len−1 forward, or Len−1..0 backward.
- Addressing: all address arithmetic is mod 2^AW, so ranges wrap past 255 to 0.
- RD (COPY):
  - MemRdAddr = Src+i.
  - At posedge, MemRdData is captured into the data register → WR.
- WR:
  - MemWrEn=1, MemWrAddr=Dst+i.
  - MemWrData = data register (COPY) or FillVal (FILL).
  - At posedge, if this was the last byte → DONE.
  - Otherwise step i; next state is RD (COPY) or WR (FILL).
- DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE unless Start=1.
- Busy: 1 in RD and WR, 0 in IDLE and DONE.
- Latency, measured from the accepting edge:
  - COPY of N bytes: 2N busy cycles; Done in cycle 2N+1.
  - FILL of N bytes: N busy cycles; Done in cycle N+1.
- Idle outputs: outside WR, MemWrEn=0 and MemWrData=0. Outside RD, MemRdAddr=0.
- Abort:
  - Abort=1 in RD or WR → IDLE at the next posedge; Done is not pulsed.
  - A write already presented in that cycle still commits (MemWrEn is not gated by Abort).
  - Abort in IDLE or DONE has no effect.
  - Abort has priority over Start.
- Output registering: MemWrEn, MemWrAddr and MemWrData are decoded from registered state only. They have no combinational path from Start.

Test Plan:
1. FILL Dst=0x10, Len=4, FillVal=0xA5 → MemWrEn high for 4 consecutive cycles at 0x10..0x13; Done pulses in cycle 5; mem[0x0F] and mem[0x14] unchanged.
2. COPY Src=0x00, Dst=0x40, Len=3, mem[0..2]={1,2,3} → forward; mem[0x40..0x42]={1,2,3}; Busy high for 6 cycles; Done in cycle 7.
3. Overlap COPY Src=0x20, Dst=0x22, Len=4, mem[0x20..0x23]={A,B,C,D} → backward; mem[0x22..0x25]={A,B,C,D}. Then Src=0x22, Dst=0x20 → forward, no corruption.
4. Wrap: FILL Dst=0xFE, Len=4 → writes at 0xFE, 0xFF, 0x00, 0x01. Len=0 → Done after one cycle, zero writes.
5. Pulse Start with new operands mid-COPY → ignored, original transfer completes. Abort after the 2nd write → Busy falls next edge, no Done, exactly 2 bytes written.
6. Reset driven low asynchronously mid-FILL → Busy, MemWrEn and Done go 0 immediately; no writes after reset; a new Start after release works normally.
